// File: rtl/dragon_segment_driver.sv
// Dragon body shift register: moves the head each step and lets the body follow.
// Optional DRAGON_SHRINK_EN adds a shrink input that shortens the body by one.
module dragon_segment_driver #(
    parameter int unsigned MOVE_PERIOD = 10,
    parameter logic [7:0]  START_POS   = 8'h85,
    parameter int unsigned START_LEN   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [1:0]  direction,
    input  logic        grow,
`ifdef DRAGON_SHRINK_EN
    input  logic        shrink,
`endif
    input  logic        halt,
    output logic [55:0] dragon_segment_positions,
    output logic [6:0]  segment_active,
    output logic [2:0]  dragon_length,
    output logic        positions_updated
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MOVE_PERIOD - 1);

    state_t state_q;
    state_t state_d;

    logic [6:0][7:0] seg_q;
    logic [6:0][7:0] seg_next;
    logic [6:0]      active_q;
    logic [6:0]      mask_next;
    logic [2:0]      len_q;
    logic [2:0]      len_next;
    logic [1:0]      last_dir_q;
    logic [1:0]      applied_dir;
    logic [7:0]      move_cnt_q;
    logic [7:0]      move_cnt_d;
    logic            grow_pend_q;
    logic            upd_q;
    logic            step;
    logic [3:0]      head_x;
    logic [3:0]      head_y;
    logic [7:0]      next_head;
`ifdef DRAGON_SHRINK_EN
    logic            shrink_pend_q;
`endif

    // Reset body: laid out leftward from the head, one cell per segment.
    function automatic logic [7:0] init_seg(input int unsigned k);
        logic [3:0] x;
        x = START_POS[7:4] - 4'(k);
        if (k < START_LEN) begin
            init_seg = {x, START_POS[3:0]};
        end else begin
            init_seg = 8'hFF;
        end
    endfunction

    assign step = (state_q == RUN) && !halt && frame_tick
                  && (move_cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        move_cnt_d = move_cnt_q;
        unique case (state_q)
            IDLE: begin
                move_cnt_d = 8'd0;
                if (frame_tick) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (frame_tick) begin
                    move_cnt_d = step ? 8'd0 : move_cnt_q + 8'd1;
                end
            end
            HALTED: begin
                if (!halt) begin
                    state_d    = RUN;
                    move_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                move_cnt_d = 8'd0;
            end
        endcase
    end

    // A request straight back into the body is dropped.
    always_comb begin
        head_x      = seg_q[0][7:4];
        head_y      = seg_q[0][3:0];
        applied_dir = direction;
        if (direction == (last_dir_q ^ 2'b10)) begin
            applied_dir = last_dir_q;
        end
        next_head = seg_q[0];
        unique case (applied_dir)
            2'b00: next_head = {head_x,
                                (head_y == 4'd0) ? 4'd11 : head_y - 4'd1};
            2'b01: next_head = {head_x + 4'd1, head_y};
            2'b10: next_head = {head_x,
                                (head_y >= 4'd11) ? 4'd0 : head_y + 4'd1};
            2'b11: next_head = {head_x - 4'd1, head_y};
            default: next_head = seg_q[0];
        endcase
    end

    always_comb begin
        len_next = len_q;
`ifdef DRAGON_SHRINK_EN
        if (grow_pend_q && !shrink_pend_q && len_q != 3'd7) begin
            len_next = len_q + 3'd1;
        end else if (shrink_pend_q && !grow_pend_q && len_q != 3'd1) begin
            len_next = len_q - 3'd1;
        end
`else
        if (grow_pend_q && len_q != 3'd7) begin
            len_next = len_q + 3'd1;
        end
`endif
        for (int i = 0; i < 7; i++) begin
            mask_next[i] = (3'(i) < len_next);
        end
        seg_next[0] = next_head;
        for (int i = 1; i < 7; i++) begin
            seg_next[i] = mask_next[i] ? seg_q[i-1] : 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 7; k++) begin
                seg_q[k]    <= init_seg(k);
                active_q[k] <= (k < START_LEN);
            end
            len_q       <= 3'(START_LEN);
            last_dir_q  <= 2'b01;
            move_cnt_q  <= 8'd0;
            grow_pend_q <= 1'b0;
            upd_q       <= 1'b0;
        end else begin
            upd_q      <= step;
            move_cnt_q <= move_cnt_d;
            // A pulse landing on the step edge waits for the following step.
            grow_pend_q <= step ? grow : (grow_pend_q | grow);
            if (step) begin
                seg_q      <= seg_next;
                active_q   <= mask_next;
                len_q      <= len_next;
                last_dir_q <= applied_dir;
            end
        end
    end

`ifdef DRAGON_SHRINK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            shrink_pend_q <= 1'b0;
        end else begin
            shrink_pend_q <= step ? shrink : (shrink_pend_q | shrink);
        end
    end
`endif

    assign dragon_segment_positions = seg_q;
    assign segment_active           = active_q;
    assign dragon_length            = len_q;
    assign positions_updated        = upd_q;

endmodule

// File: tb/tb_dragon_segment_driver.sv
// Directed bench for dragon_segment_driver with MOVE_PERIOD = 2.
module tb_dragon_segment_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [1:0]  direction;
    logic        grow;
    logic        halt;
`ifdef DRAGON_SHRINK_EN
    logic        shrink;
`endif
    logic [55:0] pos;
    logic [6:0]  act;
    logic [2:0]  len;
    logic        pu;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dragon_segment_driver #(
        .MOVE_PERIOD(2),
        .START_POS(8'h85),
        .START_LEN(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .direction(direction),
        .grow(grow),
`ifdef DRAGON_SHRINK_EN
        .shrink(shrink),
`endif
        .halt(halt),
        .dragon_segment_positions(pos),
        .segment_active(act),
        .dragon_length(len),
        .positions_updated(pu)
    );

    task automatic cycle(input logic ft);
        frame_tick = ft;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        grow       = 1'b0;
`ifdef DRAGON_SHRINK_EN
        shrink     = 1'b0;
`endif
    endtask

    task automatic do_step();
        cycle(1'b1);
        cycle(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle(1'b0);
        cycle(1'b0);
        reset = 1'b1;
        checks++;
        if (pos !== 56'hFF_FF_FF_FF_65_75_85) begin
            fails++;
            $display("FAIL reset_pos: got %h want %h", pos, 56'hFF_FF_FF_FF_65_75_85);
        end
        checks++;
        if (act !== 7'b0000111) begin
            fails++;
            $display("FAIL reset_active: got %b want %b", act, 7'b0000111);
        end
        checks++;
        if (len !== 3'd3) begin
            fails++;
            $display("FAIL reset_len: got %0d want 3", len);
        end
        checks++;
        if (pu !== 1'b0) begin
            fails++;
            $display("FAIL reset_upd: got %b want 0", pu);
        end
    endtask

    task automatic test_step_period();
        int pulses;
        pulses    = 0;
        direction = 2'b01;
        cycle(1'b1);
        cycle(1'b1);
        pulses += int'(pu);
        checks++;
        if (pos[7:0] !== 8'h85) begin
            fails++;
            $display("FAIL step_early: got %h want 85", pos[7:0]);
        end
        cycle(1'b1);
        pulses += int'(pu);
        checks++;
        if (pos !== 56'hFF_FF_FF_FF_75_85_95) begin
            fails++;
            $display("FAIL step1_pos: got %h want %h", pos, 56'hFF_FF_FF_FF_75_85_95);
        end
        cycle(1'b0);
        pulses += int'(pu);
        cycle(1'b1);
        pulses += int'(pu);
        cycle(1'b1);
        checks++;
        if (pu !== 1'b1) begin
            fails++;
            $display("FAIL step2_upd: got %b want 1", pu);
        end
        pulses += int'(pu);
        checks++;
        if (pos !== 56'hFF_FF_FF_FF_85_95_A5) begin
            fails++;
            $display("FAIL step2_pos: got %h want %h", pos, 56'hFF_FF_FF_FF_85_95_A5);
        end
        checks++;
        if (pulses != 2) begin
            fails++;
            $display("FAIL step_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reversal();
        direction = 2'b11;
        do_step();
        checks++;
        if (pos !== 56'hFF_FF_FF_FF_95_A5_B5) begin
            fails++;
            $display("FAIL rev_left: got %h want %h", pos, 56'hFF_FF_FF_FF_95_A5_B5);
        end
        direction = 2'b00;
        for (int i = 0; i < 5; i++) begin
            do_step();
        end
        checks++;
        if (pos[7:0] !== 8'hB0) begin
            fails++;
            $display("FAIL up_to_y0: got %h want B0", pos[7:0]);
        end
        do_step();
        checks++;
        if (pos[23:0] !== 24'hB1_B0_BB) begin
            fails++;
            $display("FAIL y_wrap: got %h want B1B0BB", pos[23:0]);
        end
        direction = 2'b10;
        do_step();
        checks++;
        if (pos[23:0] !== 24'hB0_BB_BA) begin
            fails++;
            $display("FAIL rev_down: got %h want B0BBBA", pos[23:0]);
        end
    endtask

    task automatic test_grow();
        direction = 2'b01;
        for (int i = 0; i < 3; i++) begin
            grow = 1'b1;
            cycle(1'b0);
        end
        do_step();
        checks++;
        if (pos !== 56'hFF_FF_FF_B0_BB_BA_CA) begin
            fails++;
            $display("FAIL grow_pos: got %h want %h", pos, 56'hFF_FF_FF_B0_BB_BA_CA);
        end
        checks++;
        if (len !== 3'd4 || act !== 7'b0001111) begin
            fails++;
            $display("FAIL grow_len: got %0d/%b want 4/0001111", len, act);
        end
        for (int i = 0; i < 3; i++) begin
            grow = 1'b1;
            cycle(1'b0);
            do_step();
        end
        checks++;
        if (len !== 3'd7 || act !== 7'b1111111) begin
            fails++;
            $display("FAIL grow_to7: got %0d/%b want 7/1111111", len, act);
        end
        grow = 1'b1;
        cycle(1'b0);
        do_step();
        checks++;
        if (len !== 3'd7) begin
            fails++;
            $display("FAIL grow_sat: got %0d want 7", len);
        end
        checks++;
        if (pos !== 56'hBB_BA_CA_DA_EA_FA_0A) begin
            fails++;
            $display("FAIL grow_sat_pos: got %h want %h", pos, 56'hBB_BA_CA_DA_EA_FA_0A);
        end
    endtask

    task automatic test_halt();
        cycle(1'b1);
        halt = 1'b1;
        cycle(1'b1);
        checks++;
        if (pu !== 1'b0 || pos !== 56'hBB_BA_CA_DA_EA_FA_0A) begin
            fails++;
            $display("FAIL halt_wins: got %b/%h want 0/%h", pu, pos, 56'hBB_BA_CA_DA_EA_FA_0A);
        end
        cycle(1'b1);
        checks++;
        if (pu !== 1'b0) begin
            fails++;
            $display("FAIL halt_hold: got %b want 0", pu);
        end
        halt = 1'b0;
        cycle(1'b0);
        cycle(1'b1);
        checks++;
        if (pu !== 1'b0) begin
            fails++;
            $display("FAIL resume_cnt: got %b want 0", pu);
        end
        cycle(1'b1);
        checks++;
        if (pu !== 1'b1 || pos !== 56'hBA_CA_DA_EA_FA_0A_1A) begin
            fails++;
            $display("FAIL resume_step: got %b/%h want 1/%h", pu, pos, 56'hBA_CA_DA_EA_FA_0A_1A);
        end
    endtask

    task automatic test_reset_mid_run();
        cycle(1'b1);
        reset = 1'b0;
        cycle(1'b1);
        checks++;
        if (pos !== 56'hFF_FF_FF_FF_65_75_85 || pu !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: got %h/%b want %h/0", pos, pu, 56'hFF_FF_FF_FF_65_75_85);
        end
        checks++;
        if (len !== 3'd3 || act !== 7'b0000111) begin
            fails++;
            $display("FAIL midrun_len: got %0d/%b want 3/0000111", len, act);
        end
        reset = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        checks++;
        if (pu !== 1'b0 || pos[7:0] !== 8'h85) begin
            fails++;
            $display("FAIL idle_tick: got %b/%h want 0/85", pu, pos[7:0]);
        end
        cycle(1'b1);
        checks++;
        if (pos !== 56'hFF_FF_FF_FF_75_85_95) begin
            fails++;
            $display("FAIL post_reset_step: got %h want %h", pos, 56'hFF_FF_FF_FF_75_85_95);
        end
    endtask

`ifdef DRAGON_SHRINK_EN
    task automatic test_shrink();
        shrink = 1'b1;
        cycle(1'b0);
        do_step();
        checks++;
        if (len !== 3'd2 || act !== 7'b0000011 || pos !== 56'hFF_FF_FF_FF_FF_95_A5) begin
            fails++;
            $display("FAIL shrink: got %0d/%b/%h want 2/0000011/%h", len, act, pos, 56'hFF_FF_FF_FF_FF_95_A5);
        end
        grow   = 1'b1;
        shrink = 1'b1;
        cycle(1'b0);
        do_step();
        checks++;
        if (len !== 3'd2 || pos !== 56'hFF_FF_FF_FF_FF_A5_B5) begin
            fails++;
            $display("FAIL grow_shrink: got %0d/%h want 2/%h", len, pos, 56'hFF_FF_FF_FF_FF_A5_B5);
        end
    endtask
`endif

    initial begin
        reset      = 1'b0;
        frame_tick = 1'b0;
        direction  = 2'b01;
        grow       = 1'b0;
        halt       = 1'b0;
`ifdef DRAGON_SHRINK_EN
        shrink     = 1'b0;
`endif
        test_reset();
        test_step_period();
        test_reversal();
        test_grow();
        test_halt();
        test_reset_mid_run();
`ifdef DRAGON_SHRINK_EN
        test_shrink();
`endif
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
